// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - RAW hazard stall / branch flush controller for a 5-stage MIPS pipe
// Optional macro FORWARD_EN: with forwarding present, only load-use hazards stall.
module hazard_stall_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_valid_i,
    input  logic [31:0] instr_i,
    input  logic        branch_taken_i,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        idex_bubble_o,
    output logic        ifid_flush_o,
    output logic        hazard_o,
    output logic [1:0]  stall_cnt_o,
    output logic [15:0] stall_total_o
);

    typedef enum logic {RUN, STALL} state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic [15:0] total;
    logic [4:0]  ex_dst, mem_dst;
    logic        ex_we, mem_we;
`ifdef FORWARD_EN
    logic        ex_load;
`endif

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic        use_rs, use_rt, dec_we, dec_load;
    logic [4:0]  dec_dst;
    logic        ex_hit, mem_hit;
    logic [1:0]  depth;
    logic        run_hazard, stall, issue;
    logic        unused_bits;

    assign opcode = instr_i[31:26];
    assign rs     = instr_i[25:21];
    assign rt     = instr_i[20:16];
    assign rd     = instr_i[15:11];

    always_comb begin
        use_rs   = 1'b0;
        use_rt   = 1'b0;
        dec_dst  = 5'd0;
        dec_we   = 1'b0;
        dec_load = 1'b0;
        case (opcode)
            6'd0:         begin use_rs = 1'b1; use_rt = 1'b1; dec_dst = rd; dec_we = 1'b1; end
            6'd35:        begin use_rs = 1'b1; dec_dst = rt; dec_we = 1'b1; dec_load = 1'b1; end
            6'd8, 6'd10:  begin use_rs = 1'b1; dec_dst = rt; dec_we = 1'b1; end
            6'd43, 6'd4,
            6'd5:         begin use_rs = 1'b1; use_rt = 1'b1; end
            default:      ;
        endcase
        // $0 is hardwired to zero, so a write to it is never a producer
        if (dec_dst == 5'd0)
            dec_we = 1'b0;
    end

    assign ex_hit  = ex_we  && ((use_rs && rs != 5'd0 && rs == ex_dst)
                             || (use_rt && rt != 5'd0 && rt == ex_dst));
    assign mem_hit = mem_we && ((use_rs && rs != 5'd0 && rs == mem_dst)
                             || (use_rt && rt != 5'd0 && rt == mem_dst));

`ifdef FORWARD_EN
    assign depth       = (ex_hit && ex_load) ? 2'd1 : 2'd0;
    assign unused_bits = ^{instr_i[10:0], mem_hit, dec_load};
`else
    assign depth       = ex_hit ? 2'd2 : (mem_hit ? 2'd1 : 2'd0);
    assign unused_bits = ^{instr_i[10:0], dec_load};
`endif

    assign run_hazard = (state == RUN) && instr_valid_i && (depth != 2'd0);
    assign stall      = !branch_taken_i && ((state == STALL) || run_hazard);
    assign issue      = instr_valid_i && !stall && !branch_taken_i;
    assign hazard_o   = !rst_i && !branch_taken_i && run_hazard;

    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        idex_bubble_o = 1'b0;
        ifid_flush_o  = 1'b0;
        if (rst_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            ifid_flush_o  = 1'b1;
        end else if (stall) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= RUN;
            cnt     <= 2'd0;
            total   <= 16'd0;
            ex_dst  <= 5'd0;
            ex_we   <= 1'b0;
            mem_dst <= 5'd0;
            mem_we  <= 1'b0;
`ifdef FORWARD_EN
            ex_load <= 1'b0;
`endif
        end else begin
            mem_dst <= ex_dst;
            mem_we  <= ex_we;
            ex_dst  <= issue ? dec_dst : 5'd0;
            ex_we   <= issue && dec_we;
`ifdef FORWARD_EN
            ex_load <= issue && dec_load;
`endif
            if (stall && total != 16'hFFFF)
                total <= total + 16'd1;
            // Flush outranks any stall bookkeeping
            if (branch_taken_i) begin
                state <= RUN;
                cnt   <= 2'd0;
            end else if (state == STALL) begin
                if (cnt == 2'd1) begin
                    state <= RUN;
                    cnt   <= 2'd0;
                end else begin
                    cnt <= cnt - 2'd1;
                end
            end else if (run_hazard && depth == 2'd2) begin
                state <= STALL;
                cnt   <= 2'd1;
            end
        end
    end

    assign stall_cnt_o   = cnt;
    assign stall_total_o = total;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst, valid, br;
    logic [31:0] instr;
    logic        pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o, hazard_o;
    logic [1:0]  stall_cnt_o;
    logic [15:0] stall_total_o;

    always #5 clk = ~clk;

    hazard_stall_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_valid_i  (valid),
        .instr_i        (instr),
        .branch_taken_i (br),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .idex_bubble_o  (idex_bubble_o),
        .ifid_flush_o   (ifid_flush_o),
        .hazard_o       (hazard_o),
        .stall_cnt_o    (stall_cnt_o),
        .stall_total_o  (stall_total_o)
    );

    wire [4:0] ctl = {pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o, hazard_o};

    int checks = 0;
    int fails  = 0;

    // Reference model: owed bubbles, bubble total, and the list of what entered EX each cycle
    int m_left  = 0;
    int m_total = 0;
    int dq[$];
    bit lq[$];
    logic        cur_v, cur_b, cur_r;
    logic [31:0] cur_i;
    logic [4:0]  exp_ctl;
    logic [1:0]  exp_cnt;
    logic [15:0] exp_total;

    function automatic logic [31:0] r_type(input logic [4:0] s, t, d, input logic [5:0] funct);
        return {6'd0, s, t, d, 5'd0, funct};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s, t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    function automatic void decode(input logic [31:0] ins, output int s1, output int s2,
                                   output int d, output bit ld);
        int op, a, b, c;
        op = int'(ins[31:26]); a = int'(ins[25:21]); b = int'(ins[20:16]); c = int'(ins[15:11]);
        s1 = -1; s2 = -1; d = -1; ld = 0;
        case (op)
            0:        begin s1 = a; s2 = b; d = c; end
            35:       begin s1 = a; d = b; ld = 1; end
            8, 10:    begin s1 = a; d = b; end
            43, 4, 5: begin s1 = a; s2 = b; end
            default:  ;
        endcase
        if (s1 == 0) s1 = -1;
        if (s2 == 0) s2 = -1;
        if (d == 0)  d = -1;
    endfunction

    function automatic int depth(input logic [31:0] ins);
        int s[2];
        int d, n;
        bit ld;
        decode(ins, s[0], s[1], d, ld);
        n = 0;
        for (int k = 0; k < 2; k++) begin
            if (s[k] >= 0) begin
`ifdef FORWARD_EN
                if (s[k] == dq[dq.size()-1] && lq[lq.size()-1]) n = 1;
`else
                if (s[k] == dq[dq.size()-1]) n = 2;
                else if (s[k] == dq[dq.size()-2] && n == 0) n = 1;
`endif
            end
        end
        return n;
    endfunction

    function automatic void push(input int d, input bit ld);
        dq.push_back(d);
        lq.push_back(ld);
        if (dq.size() > 4) begin
            dq.delete(0);
            lq.delete(0);
        end
    endfunction

    task automatic present(input logic v, input logic [31:0] ins, input logic b, input logic r);
        @(negedge clk);
        valid = v; instr = ins; br = b; rst = r;
        cur_v = v; cur_i = ins; cur_b = b; cur_r = r;
        #1;
        exp_cnt   = m_left[1:0];
        exp_total = m_total[15:0];
        if (r)                          exp_ctl = 5'b00100;
        else if (b)                     exp_ctl = 5'b10110;
        else if (m_left > 0)            exp_ctl = 5'b00100;
        else if (v && depth(ins) > 0)   exp_ctl = 5'b00101;
        else                            exp_ctl = 5'b11000;
    endtask

    task automatic advance();
        int s1, s2, d, n;
        bit ld;
        @(posedge clk);
        if (cur_r) begin
            m_left = 0; m_total = 0;
            dq.delete(); lq.delete();
            push(-1, 0); push(-1, 0);
        end else if (cur_b) begin
            m_left = 0;
            push(-1, 0);
        end else if (m_left > 0) begin
            m_left--;
            if (m_total < 65535) m_total++;
            push(-1, 0);
        end else begin
            n = cur_v ? depth(cur_i) : 0;
            if (n > 0) begin
                m_left = n - 1;
                if (m_total < 65535) m_total++;
                push(-1, 0);
            end else if (cur_v) begin
                decode(cur_i, s1, s2, d, ld);
                push(d, ld);
            end else begin
                push(-1, 0);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            present(1'b0, 32'd0, 1'b0, 1'b0);
            advance();
        end
    endtask

    // Presents one instruction until it issues; bounded so a stuck stall shows up as 99 bubbles
    task automatic issue_instr(input logic [31:0] ins, output int bubbles, output int pulses, output int maxcnt);
        bit done;
        bubbles = 0; pulses = 0; maxcnt = 0; done = 0;
        for (int i = 0; i < 6 && !done; i++) begin
            present(1'b1, ins, 1'b0, 1'b0);
            if (hazard_o === 1'b1) pulses++;
            if (int'(stall_cnt_o) > maxcnt) maxcnt = int'(stall_cnt_o);
            if (pc_write_o === 1'b1) done = 1;
            else bubbles++;
            advance();
        end
        if (!done) bubbles = 99;
    endtask

    task automatic test_reset();
        present(1'b0, 32'd0, 1'b1, 1'b1);
        checks++;
        if (ctl !== 5'b00100) begin fails++; $display("FAIL reset_ctl got %b want %b", ctl, 5'b00100); end
        advance();
        present(1'b1, r_type(5'd1, 5'd2, 5'd3, 6'h20), 1'b0, 1'b0);
        checks++;
        if (stall_cnt_o !== 2'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", stall_cnt_o); end
        checks++;
        if (stall_total_o !== 16'd0) begin fails++; $display("FAIL reset_total got %0d want 0", stall_total_o); end
        checks++;
        if (ctl !== 5'b11000) begin fails++; $display("FAIL reset_first_ctl got %b want %b", ctl, 5'b11000); end
        advance();
    endtask

    task automatic test_raw_two();
        int b, p, mc, t0, wb, wmc;
        idle(3);
        t0 = int'(stall_total_o);
        issue_instr(r_type(5'd1, 5'd2, 5'd3, 6'h20), b, p, mc);
        issue_instr(r_type(5'd3, 5'd4, 5'd5, 6'h22), b, p, mc);
`ifdef FORWARD_EN
        wb = 0; wmc = 0;
`else
        wb = 2; wmc = 1;
`endif
        checks++;
        if (b !== wb) begin fails++; $display("FAIL raw_bubbles got %0d want %0d", b, wb); end
        checks++;
        if (mc !== wmc) begin fails++; $display("FAIL raw_cnt got %0d want %0d", mc, wmc); end
        checks++;
        if (int'(stall_total_o) - t0 !== wb) begin
            fails++; $display("FAIL raw_total got %0d want %0d", int'(stall_total_o) - t0, wb);
        end
    endtask

    task automatic test_load_use();
        int b, p, mc, wb, wmc;
        idle(3);
        issue_instr(i_type(6'd35, 5'd1, 5'd2, 16'd0), b, p, mc);
        issue_instr(r_type(5'd2, 5'd3, 5'd4, 6'h20), b, p, mc);
`ifdef FORWARD_EN
        wb = 1; wmc = 0;
`else
        wb = 2; wmc = 1;
`endif
        checks++;
        if (b !== wb) begin fails++; $display("FAIL lu_bubbles got %0d want %0d", b, wb); end
        checks++;
        if (mc !== wmc) begin fails++; $display("FAIL lu_cnt got %0d want %0d", mc, wmc); end
    endtask

    task automatic test_gap();
        int b, p, mc, wb;
        idle(3);
        issue_instr(r_type(5'd1, 5'd2, 5'd3, 6'h20), b, p, mc);
        issue_instr(r_type(5'd7, 5'd8, 5'd6, 6'h25), b, p, mc);
        checks++;
        if (b !== 0) begin fails++; $display("FAIL gap_or_bubbles got %0d want 0", b); end
        issue_instr(r_type(5'd3, 5'd4, 5'd5, 6'h22), b, p, mc);
`ifdef FORWARD_EN
        wb = 0;
`else
        wb = 1;
`endif
        checks++;
        if (b !== wb) begin fails++; $display("FAIL gap_bubbles got %0d want %0d", b, wb); end
        checks++;
        if (p !== wb) begin fails++; $display("FAIL gap_hazard_pulses got %0d want %0d", p, wb); end
    endtask

    task automatic test_zero_reg();
        int b, p, mc;
        idle(3);
        issue_instr(i_type(6'd8, 5'd0, 5'd0, 16'd1), b, p, mc);
        issue_instr(r_type(5'd0, 5'd0, 5'd1, 6'h20), b, p, mc);
        checks++;
        if (b !== 0) begin fails++; $display("FAIL zero_bubbles got %0d want 0", b); end
        checks++;
        if (p !== 0) begin fails++; $display("FAIL zero_hazard got %0d want 0", p); end
    endtask

    task automatic test_flush_in_stall();
        int b, p, mc, t0;
        idle(3);
        issue_instr(r_type(5'd1, 5'd2, 5'd3, 6'h20), b, p, mc);
        present(1'b1, r_type(5'd3, 5'd4, 5'd5, 6'h22), 1'b0, 1'b0);
        advance();
        present(1'b1, r_type(5'd3, 5'd4, 5'd5, 6'h22), 1'b1, 1'b0);
        checks++;
        if (ifid_flush_o !== 1'b1 || idex_bubble_o !== 1'b1) begin
            fails++; $display("FAIL flush_outputs got flush=%b bubble=%b want 1 1", ifid_flush_o, idex_bubble_o);
        end
        checks++;
        if (ctl !== exp_ctl) begin fails++; $display("FAIL flush_ctl got %b want %b", ctl, exp_ctl); end
        t0 = int'(stall_total_o);
        advance();
        present(1'b0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (stall_cnt_o !== 2'd0 || pc_write_o !== 1'b1) begin
            fails++; $display("FAIL flush_after got cnt=%0d pc=%b want 0 1", stall_cnt_o, pc_write_o);
        end
        checks++;
        if (int'(stall_total_o) !== t0) begin fails++; $display("FAIL flush_total got %0d want %0d", stall_total_o, t0); end
        advance();
    endtask

    task automatic test_reset_mid_stall();
        int b, p, mc, wb;
        idle(3);
        issue_instr(r_type(5'd1, 5'd2, 5'd3, 6'h20), b, p, mc);
        present(1'b1, r_type(5'd3, 5'd4, 5'd5, 6'h22), 1'b0, 1'b0);
        advance();
        present(1'b1, r_type(5'd3, 5'd4, 5'd5, 6'h22), 1'b1, 1'b1);
        checks++;
        if (ctl !== 5'b00100) begin fails++; $display("FAIL rst_mid_ctl got %b want %b", ctl, 5'b00100); end
        advance();
        present(1'b0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (stall_cnt_o !== 2'd0 || stall_total_o !== 16'd0 || pc_write_o !== 1'b1) begin
            fails++; $display("FAIL rst_mid_after got cnt=%0d total=%0d pc=%b want 0 0 1", stall_cnt_o, stall_total_o, pc_write_o);
        end
        advance();
        issue_instr(r_type(5'd1, 5'd2, 5'd3, 6'h20), b, p, mc);
        issue_instr(r_type(5'd3, 5'd4, 5'd5, 6'h22), b, p, mc);
`ifdef FORWARD_EN
        wb = 0;
`else
        wb = 2;
`endif
        checks++;
        if (b !== wb) begin fails++; $display("FAIL rst_mid_rebuild got %0d want %0d", b, wb); end
    endtask

    task automatic test_random();
        logic [5:0]  ops [8] = '{6'd0, 6'd35, 6'd8, 6'd10, 6'd43, 6'd4, 6'd5, 6'd2};
        logic [31:0] ins;
        logic        v, b, r;
        for (int i = 0; i < 600; i++) begin
            ins = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 11'($urandom)};
            v = ($urandom_range(0, 3) != 0);
            b = ($urandom_range(0, 11) == 0);
            r = ($urandom_range(0, 59) == 0);
            present(v, ins, b, r);
            checks++;
            if (ctl !== exp_ctl) begin fails++; $display("FAIL rand_ctl cyc %0d got %b want %b", i, ctl, exp_ctl); end
            checks++;
            if (stall_cnt_o !== exp_cnt) begin fails++; $display("FAIL rand_cnt cyc %0d got %0d want %0d", i, stall_cnt_o, exp_cnt); end
            checks++;
            if (stall_total_o !== exp_total) begin
                fails++; $display("FAIL rand_total cyc %0d got %0d want %0d", i, stall_total_o, exp_total);
            end
            advance();
        end
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; br = 1'b0; instr = 32'd0;
        push(-1, 0); push(-1, 0);
        test_reset();
        test_raw_two();
        test_load_use();
        test_gap();
        test_zero_reg();
        test_flush_in_stall();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
